// File: rtl/apb_rr_master.sv
// ---------------------------------------------------------------------------
// apb_rr_master
//
// Purpose:
//   Shares one APB bus between NUM_REQ on-chip requesters. A round-robin
//   arbiter picks one command per grant. The command runs as a legal APB
//   transfer: SETUP, then ACCESS, with PREADY wait states. The result goes
//   back to the owning requester as a one-cycle response pulse.
//
// Ports:
//   PCLK, PRESETn        clock (rising edge) and synchronous active-low reset
//   req_valid/req_ready  per-requester command handshake (ready is one-hot
//                        or zero, combinational)
//   req_addr/req_write/req_wdata/req_strb/req_prot
//                        packed per-requester command fields, slice i
//                        belongs to requester i
//   rsp_valid            one-cycle response pulse to the owning requester
//   rsp_rdata, rsp_err   read data / slave error, valid with rsp_valid
//   PSEL..PSTRB          registered APB master outputs
//   PREADY, PSLVERR, PRDATA
//                        APB slave inputs
// ---------------------------------------------------------------------------
module apb_rr_master #(
    parameter int NUM_REQ        = 2,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
) (
    input  logic                                   PCLK,
    input  logic                                   PRESETn,

    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]      req_addr,
    input  logic [NUM_REQ-1:0]                     req_write,
    input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]      req_wdata,
    input  logic [NUM_REQ*(APB_DATA_WIDTH/8)-1:0]  req_strb,
    input  logic [NUM_REQ*3-1:0]                   req_prot,

    output logic [NUM_REQ-1:0]                     rsp_valid,
    output logic [APB_DATA_WIDTH-1:0]              rsp_rdata,
    output logic                                   rsp_err,

    output logic                                   PSEL,
    output logic                                   PENABLE,
    output logic                                   PWRITE,
    output logic [APB_ADDR_WIDTH-1:0]              PADDR,
    output logic [2:0]                             PPROT,
    output logic [APB_DATA_WIDTH-1:0]              PWDATA,
    output logic [APB_DATA_WIDTH/8-1:0]            PSTRB,
    input  logic                                   PREADY,
    input  logic                                   PSLVERR,
    input  logic [APB_DATA_WIDTH-1:0]              PRDATA
);

    localparam int STRB_W = APB_DATA_WIDTH / 8;
    localparam int GW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } state_t;

    // ---------------------------------------------------------------------
    // State and registered outputs
    // ---------------------------------------------------------------------
    state_t                     state_r;
    state_t                     state_nxt_s;

    logic                       psel_r;
    logic                       penable_r;
    logic                       pwrite_r;
    logic [APB_ADDR_WIDTH-1:0]  paddr_r;
    logic [2:0]                 pprot_r;
    logic [APB_DATA_WIDTH-1:0]  pwdata_r;
    logic [STRB_W-1:0]          pstrb_r;

    // last_grant_r also names the owner of the transfer in flight, because
    // it is loaded with the winner at the same edge as the command.
    logic [GW-1:0]              last_grant_r;

    logic [NUM_REQ-1:0]         rsp_valid_r;
    logic [APB_DATA_WIDTH-1:0]  rsp_rdata_r;
    logic                       rsp_err_r;

    // Next-state values for the registers
    logic                       psel_nxt_s;
    logic                       penable_nxt_s;
    logic                       pwrite_nxt_s;
    logic [APB_ADDR_WIDTH-1:0]  paddr_nxt_s;
    logic [2:0]                 pprot_nxt_s;
    logic [APB_DATA_WIDTH-1:0]  pwdata_nxt_s;
    logic [STRB_W-1:0]          pstrb_nxt_s;
    logic [GW-1:0]              last_grant_nxt_s;
    logic [NUM_REQ-1:0]         rsp_valid_nxt_s;
    logic [APB_DATA_WIDTH-1:0]  rsp_rdata_nxt_s;
    logic                       rsp_err_nxt_s;

    // Arbitration
    logic                       arb_point_s;
    logic                       win_found_s;
    logic [GW-1:0]              win_idx_s;
    logic                       grant_s;
    logic                       complete_s;
    int                         scan_idx_s;

    // Arbitration is allowed in IDLE, or in ACCESS during the completing cycle
    always_comb begin
        arb_point_s = 1'b0;
        complete_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                arb_point_s = 1'b1;
            end
            ST_ACCESS: begin
                arb_point_s = PREADY;
                complete_s  = PREADY;
            end
            default: begin
                arb_point_s = 1'b0;
                complete_s  = 1'b0;
            end
        endcase
    end

    // Round-robin scan starting just after the previous winner, with wrap-around
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        scan_idx_s  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx_s = (int'(last_grant_r) + k) % NUM_REQ;
            if (!win_found_s && req_valid[scan_idx_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = GW'(scan_idx_s);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Reset gates the grant so no command is accepted while PRESETn is low
    assign grant_s = arb_point_s && win_found_s && PRESETn;

    // One-hot ready to the winner
    always_comb begin
        req_ready = '0;
        if (grant_s) begin
            req_ready[win_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state logic of the APB sequencing FSM
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_nxt_s = ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_nxt_s = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (!PREADY) begin
                    state_nxt_s = ST_ACCESS;
                end else if (grant_s) begin
                    // back-to-back: skip IDLE entirely
                    state_nxt_s = ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next values of APB control and command fields; fields hold unless a new grant loads them
    always_comb begin
        psel_nxt_s       = (state_nxt_s != ST_IDLE);
        penable_nxt_s    = (state_nxt_s == ST_ACCESS);
        pwrite_nxt_s     = pwrite_r;
        paddr_nxt_s      = paddr_r;
        pprot_nxt_s      = pprot_r;
        pwdata_nxt_s     = pwdata_r;
        pstrb_nxt_s      = pstrb_r;
        last_grant_nxt_s = last_grant_r;
        if (grant_s) begin
            pwrite_nxt_s     = req_write[win_idx_s];
            paddr_nxt_s      = req_addr[int'(win_idx_s)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
            pprot_nxt_s      = req_prot[int'(win_idx_s)*3 +: 3];
            pwdata_nxt_s     = req_wdata[int'(win_idx_s)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            // reads never carry strobes
            if (req_write[win_idx_s]) begin
                pstrb_nxt_s = req_strb[int'(win_idx_s)*STRB_W +: STRB_W];
            end else begin
                pstrb_nxt_s = '0;
            end
            last_grant_nxt_s = win_idx_s;
        end else begin
            last_grant_nxt_s = last_grant_r;
        end
    end

    // Response pulse: data and error hold between responses, valid lasts one cycle
    always_comb begin
        rsp_valid_nxt_s = '0;
        rsp_rdata_nxt_s = rsp_rdata_r;
        rsp_err_nxt_s   = rsp_err_r;
        if (complete_s) begin
            rsp_valid_nxt_s[last_grant_r] = 1'b1;
            rsp_err_nxt_s                 = PSLVERR;
            if (pwrite_r) begin
                rsp_rdata_nxt_s = '0;
            end else begin
                rsp_rdata_nxt_s = PRDATA;
            end
        end else begin
            rsp_valid_nxt_s = '0;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_r      <= ST_IDLE;
            psel_r       <= 1'b0;
            penable_r    <= 1'b0;
            pwrite_r     <= 1'b0;
            paddr_r      <= '0;
            pprot_r      <= 3'b000;
            pwdata_r     <= '0;
            pstrb_r      <= '0;
            last_grant_r <= GW'(NUM_REQ - 1);
            rsp_valid_r  <= '0;
            rsp_rdata_r  <= '0;
            rsp_err_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            psel_r       <= psel_nxt_s;
            penable_r    <= penable_nxt_s;
            pwrite_r     <= pwrite_nxt_s;
            paddr_r      <= paddr_nxt_s;
            pprot_r      <= pprot_nxt_s;
            pwdata_r     <= pwdata_nxt_s;
            pstrb_r      <= pstrb_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            rsp_valid_r  <= rsp_valid_nxt_s;
            rsp_rdata_r  <= rsp_rdata_nxt_s;
            rsp_err_r    <= rsp_err_nxt_s;
        end
    end

    assign PSEL      = psel_r;
    assign PENABLE   = penable_r;
    assign PWRITE    = pwrite_r;
    assign PADDR     = paddr_r;
    assign PPROT     = pprot_r;
    assign PWDATA    = pwdata_r;
    assign PSTRB     = pstrb_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_apb_rr_master.sv
// ---------------------------------------------------------------------------
// tb_apb_rr_master
//
// Directed bench for apb_rr_master with three requesters. The bench plays
// the APB slave by driving PREADY/PSLVERR/PRDATA itself. Inputs change 2
// time units after each rising edge. Registered outputs are sampled there.
// Combinational req_ready is sampled 1 unit later.
// ---------------------------------------------------------------------------
module tb_apb_rr_master;

    localparam int NR = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              PCLK;
    logic              PRESETn;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_addr;
    logic [NR-1:0]     req_write;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR*4-1:0]   req_strb;
    logic [NR*3-1:0]   req_prot;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [AW-1:0]     PADDR;
    logic [2:0]        PPROT;
    logic [DW-1:0]     PWDATA;
    logic [3:0]        PSTRB;
    logic              PREADY;
    logic              PSLVERR;
    logic [DW-1:0]     PRDATA;

    int tests = 0;
    int fails = 0;
    int acc_cnt [NR];
    int rsp_cnt [NR];

    apb_rr_master #(
        .NUM_REQ        (NR),
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .req_prot  (req_prot),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PPROT     (PPROT),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .PRDATA    (PRDATA)
    );

    // Free-running clock
    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // Watchdog so the run always ends
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_cmd(input int i, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
        req_addr[i*AW +: AW] = a;
        req_write[i]         = w;
        req_wdata[i*DW +: DW] = d;
        req_strb[i*4 +: 4]   = s;
        req_prot[i*3 +: 3]   = p;
    endtask

    task automatic do_reset();
        PRESETn   = 1'b0;
        req_valid = 3'b000;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        tick();
        tick();
        PRESETn = 1'b1;
        tick();
    endtask

    // Holds req_valid=mask and checks n back-to-back grants against ord
    // (2-bit winner fields, grant g at bits [2g+1:2g]); requester i reads
    // address 0x1000*(i+1).
    task automatic run_order(input int n, input logic [2:0] mask, input logic [15:0] ord);
        logic [1:0] w;
        logic [1:0] wp;
        w  = 2'd0;
        wp = 2'd0;
        req_valid = mask;
        PREADY    = 1'b1;
        PSLVERR   = 1'b0;
        settle();
        for (int g = 0; g < n; g++) begin
            w = ord[2*g +: 2];
            chk("rr_ready", req_ready, 64'(3'b001 << w));
            tick();
            chk("rr_setup_ctrl", {PSEL, PENABLE}, 64'(2'b10));
            chk("rr_setup_paddr", PADDR, 64'(32'h1000 * (32'(w) + 32'd1)));
            if (g > 0) begin
                chk("rr_prev_rsp", rsp_valid, 64'(3'b001 << wp));
            end else begin
                chk("rr_first_no_rsp", rsp_valid, 64'(3'b000));
            end
            tick();
            chk("rr_access_ctrl", {PSEL, PENABLE}, 64'(2'b11));
            if (g == n - 1) begin
                req_valid = 3'b000;
            end
            wp = w;
            settle();
        end
        tick();
        chk("rr_last_rsp", rsp_valid, 64'(3'b001 << wp));
        chk("rr_idle_psel", PSEL, 64'(1'b0));
        tick();
    endtask

    initial begin
        logic [2:0] gm;
        PRESETn   = 1'b0;
        req_valid = 3'b111;
        req_addr  = '0;
        req_write = '0;
        req_wdata = '0;
        req_strb  = '0;
        req_prot  = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        PRDATA    = 32'h0;
        for (int i = 0; i < NR; i++) begin
            acc_cnt[i] = 0;
            rsp_cnt[i] = 0;
        end

        // ---------------- reset state ----------------
        tick();
        tick();
        settle();
        chk("rst_ready", req_ready, 64'(3'b000));
        chk("rst_ctrl", {PSEL, PENABLE, PWRITE}, 64'(3'b000));
        chk("rst_paddr", PADDR, 64'(32'h0));
        chk("rst_pwdata", PWDATA, 64'(32'h0));
        chk("rst_pstrb_pprot", {PSTRB, PPROT}, 64'(7'h00));
        chk("rst_rsp", {rsp_valid, rsp_err}, 64'(4'h0));
        chk("rst_rdata", rsp_rdata, 64'(32'h0));
        req_valid = 3'b000;
        PRESETn   = 1'b1;
        tick();

        // ---------------- single read ----------------
        set_cmd(0, 32'h100, 1'b0, 32'h0, 4'hF, 3'b000);
        PREADY    = 1'b1;
        PSLVERR   = 1'b0;
        PRDATA    = 32'hDEADBEEF;
        req_valid = 3'b001;
        settle();
        chk("rd_ready", req_ready, 64'(3'b001));
        tick();
        req_valid = 3'b000;
        chk("rd_setup_ctrl", {PSEL, PENABLE}, 64'(2'b10));
        chk("rd_paddr", PADDR, 64'(32'h100));
        chk("rd_pwrite", PWRITE, 64'(1'b0));
        chk("rd_pstrb_setup", PSTRB, 64'(4'h0));
        settle();
        chk("rd_no_ready_setup", req_ready, 64'(3'b000));
        tick();
        chk("rd_access_ctrl", {PSEL, PENABLE}, 64'(2'b11));
        chk("rd_pstrb_access", PSTRB, 64'(4'h0));
        chk("rd_no_early_rsp", rsp_valid, 64'(3'b000));
        tick();
        chk("rd_rsp_valid", rsp_valid, 64'(3'b001));
        chk("rd_rsp_rdata", rsp_rdata, 64'(32'hDEADBEEF));
        chk("rd_rsp_err", rsp_err, 64'(1'b0));
        chk("rd_idle_psel", PSEL, 64'(1'b0));
        tick();
        chk("rd_rsp_pulse_end", rsp_valid, 64'(3'b000));
        chk("rd_rdata_hold", rsp_rdata, 64'(32'hDEADBEEF));

        // ---------------- write with wait states and error ----------------
        set_cmd(0, 32'h20, 1'b1, 32'h5A5A5A5A, 4'hF, 3'b010);
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        PRDATA    = 32'h12345678;
        req_valid = 3'b001;
        settle();
        chk("wr_ready", req_ready, 64'(3'b001));
        tick();
        req_valid = 3'b000;
        chk("wr_setup_ctrl", {PSEL, PENABLE}, 64'(2'b10));
        tick();
        for (int a = 0; a < 4; a++) begin
            chk("wr_wait_ctrl", {PSEL, PENABLE, PWRITE}, 64'(3'b111));
            chk("wr_wait_paddr", PADDR, 64'(32'h20));
            chk("wr_wait_pwdata", PWDATA, 64'(32'h5A5A5A5A));
            chk("wr_wait_pstrb_pprot", {PSTRB, PPROT}, 64'({4'hF, 3'b010}));
            chk("wr_wait_no_rsp", rsp_valid, 64'(3'b000));
            if (a == 3) begin
                PREADY  = 1'b1;
                PSLVERR = 1'b1;
            end else begin
                PREADY  = 1'b0;
            end
            tick();
        end
        chk("wr_rsp_valid", rsp_valid, 64'(3'b001));
        chk("wr_rsp_err", rsp_err, 64'(1'b1));
        chk("wr_rsp_rdata_zero", rsp_rdata, 64'(32'h0));
        chk("wr_idle_psel", PSEL, 64'(1'b0));
        PSLVERR = 1'b0;
        tick();
        chk("wr_single_pulse_a", rsp_valid, 64'(3'b000));
        tick();
        chk("wr_single_pulse_b", rsp_valid, 64'(3'b000));

        // ---------------- round robin, all three pending ----------------
        do_reset();
        set_cmd(0, 32'h1000, 1'b0, 32'h0, 4'h0, 3'b000);
        set_cmd(1, 32'h2000, 1'b0, 32'h0, 4'h0, 3'b001);
        set_cmd(2, 32'h3000, 1'b0, 32'h0, 4'h0, 3'b010);
        PRDATA = 32'hCAFE0001;
        run_order(6, 3'b111, 16'h0924);

        // ---------------- fairness between 0 and 1 ----------------
        run_order(4, 3'b011, 16'h0044);

        // ---------------- reset in the middle of a stalled ACCESS ----------------
        PREADY    = 1'b0;
        req_valid = 3'b010;
        settle();
        chk("mrst_ready", req_ready, 64'(3'b010));
        tick();
        req_valid = 3'b000;
        tick();
        chk("mrst_access", {PSEL, PENABLE}, 64'(2'b11));
        PRESETn   = 1'b0;
        req_valid = 3'b111;
        settle();
        chk("mrst_ready_forced", req_ready, 64'(3'b000));
        tick();
        chk("mrst_ctrl_dropped", {PSEL, PENABLE}, 64'(2'b00));
        chk("mrst_no_rsp", rsp_valid, 64'(3'b000));
        PRESETn = 1'b1;
        settle();
        chk("mrst_first_grant", req_ready, 64'(3'b001));
        req_valid = 3'b000;
        PREADY    = 1'b1;
        tick();
        chk("mrst_no_rsp_after_a", rsp_valid, 64'(3'b000));
        tick();
        chk("mrst_no_rsp_after_b", rsp_valid, 64'(3'b000));

        // ---------------- random traffic ----------------
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 3) == 0)) begin
                    set_cmd(i, $urandom, 1'($urandom_range(0, 1)), $urandom,
                            4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
                    req_valid[i] = 1'b1;
                end
            end
            PREADY  = ($urandom_range(0, 2) != 0);
            PSLVERR = 1'($urandom_range(0, 1));
            PRDATA  = $urandom;
            settle();
            chk("rnd_ready_onehot0", $onehot0(req_ready), 64'(1'b1));
            chk("rnd_ready_needs_valid", req_ready & ~req_valid, 64'(3'b000));
            gm = req_ready & req_valid;
            for (int i = 0; i < NR; i++) begin
                if (gm[i]) acc_cnt[i]++;
            end
            tick();
            req_valid = req_valid & ~gm;
            for (int i = 0; i < NR; i++) begin
                if (rsp_valid[i]) rsp_cnt[i]++;
            end
            chk("rnd_rsp_onehot0", $onehot0(rsp_valid), 64'(1'b1));
            chk("rnd_penable_needs_psel", PENABLE & ~PSEL, 64'(1'b0));
        end
        req_valid = 3'b000;
        PREADY    = 1'b1;
        for (int d = 0; d < 6; d++) begin
            tick();
            for (int i = 0; i < NR; i++) begin
                if (rsp_valid[i]) rsp_cnt[i]++;
            end
        end
        chk("rnd_count_req0", 64'(rsp_cnt[0]), 64'(acc_cnt[0]));
        chk("rnd_count_req1", 64'(rsp_cnt[1]), 64'(acc_cnt[1]));
        chk("rnd_count_req2", 64'(rsp_cnt[2]), 64'(acc_cnt[2]));
        chk("rnd_drained_idle", PSEL, 64'(1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Multi-requester APB master that shares one APB bus between NUM_REQ on-chip requesters using round-robin arbitration.
- Accepts one command per grant over a valid/ready interface. Sequences it as a protocol-legal APB transfer: SETUP, then ACCESS with PREADY wait states. Returns PRDATA/PSLVERR to the granted requester as a one-cycle response pulse.
- Sits between the subsystem's bus initiators and the APB slave fabric. All its APB outputs must pass the team's APB protocol checker interface without error.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- APB_ADDR_WIDTH, 32, PADDR/req_addr width.
- APB_DATA_WIDTH, 32, PWDATA/PRDATA width; PSTRB width is APB_DATA_WIDTH/8.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESETn  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester command accepted (one-hot or zero, combinational).
- req_addr  in  NUM_REQ*APB_ADDR_WIDTH  packed address, requester i at slice i.
- req_write  in  NUM_REQ  1=write, 0=read.
- req_wdata  in  NUM_REQ*APB_DATA_WIDTH  packed write data.
- req_strb  in  NUM_REQ*APB_DATA_WIDTH/8  packed write strobes.
- req_prot  in  NUM_REQ*3  packed protection attributes.
- rsp_valid  out  NUM_REQ  one-cycle response pulse to the owning requester.
- rsp_rdata  out  APB_DATA_WIDTH  read data, valid with rsp_valid.
- rsp_err  out  1  PSLVERR of the completed transfer, valid with rsp_valid.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR  out  APB_ADDR_WIDTH.
- PPROT  out  3.
- PWDATA  out  APB_DATA_WIDTH.
- PSTRB  out  APB_DATA_WIDTH/8.
- PREADY, PSLVERR  in  1 each.
- PRDATA  in  APB_DATA_WIDTH.

Behaviour:
- States: IDLE (PSEL=0), SETUP (PSEL=1, PENABLE=0), ACCESS (PSEL=1, PENABLE=1). All APB outputs and rsp_* are registered.
- Reset (PRESETn=0 at an edge):
  - State goes to IDLE.
  - All APB outputs go to 0, and rsp_valid and rsp_err go to 0.
  - rsp_rdata goes to 0.
  - last_grant goes to NUM_REQ-1, so requester 0 has highest priority first.
  - A transfer in flight is dropped: PSEL=0 on the next cycle and no response is issued.
  - req_ready is forced to 0 while PRESETn=0.
- Arbitration points:
  - Arbitration happens only in IDLE, or in ACCESS when PREADY=1.
  - The winner is the first i with req_valid[i]=1 scanning (last_grant+1) mod NUM_REQ upward, with wrap-around.
  - req_ready[winner]=1 combinationally in that cycle; all other req_ready bits are 0.
  - At the next edge, the winner's command is latched onto PADDR/PWRITE/PWDATA/PSTRB/PPROT, last_grant becomes the winner, and state goes to SETUP.
- If no request is pending at an arbitration point, state goes to IDLE and PSEL=0.
- SETUP always goes to ACCESS after exactly 1 cycle.
- ACCESS with PREADY=0: wait state. All APB outputs are held.
- ACCESS with PREADY=1: completion.
  - On the next cycle, rsp_valid[owner]=1 for exactly 1 cycle, with rsp_rdata=PRDATA (reads) or 0 (writes) and rsp_err=PSLVERR.
  - rsp_rdata holds its value until the next response.
  - A back-to-back grant in the same cycle gives SETUP next, with no IDLE cycle.
- Latency: accept in cycle T gives PSEL=1 at T+1, PENABLE=1 at T+2, and earliest rsp_valid at T+3. Back-to-back throughput is one transfer per 2 cycles.
- Reads drive PSTRB=0 regardless of req_strb.
- PADDR/PWRITE/PPROT/PSTRB/PWDATA:
  - Stable from SETUP through the completing ACCESS cycle.
  - Held at their last values in IDLE, so there are no spurious toggles.
- Requesters must hold command fields stable while req_valid=1 and req_ready=0. A requester may drop req_valid before grant; it then receives nothing.
- A requester may present its next command while its previous response is pending. That command is only eligible at the next arbitration point.
- No timeout: a slave holding PREADY=0 stalls the bus indefinitely, as APB requires.

Test Plan:
- Single read: req_valid[0]=1, addr=0x100, write=0, slave PREADY=1 immediately, PRDATA=0xDEADBEEF
  -> req_ready[0] at T, PSEL at T+1, PENABLE at T+2, rsp_valid[0]=1 with rsp_rdata=0xDEADBEEF and rsp_err=0 at T+3, PSTRB=0 throughout.
- Wait states with error: write addr=0x20, wdata=0x5A5A5A5A, strb=0xF, PREADY low for 3 ACCESS cycles then high with PSLVERR=1
  -> PADDR/PWDATA/PSTRB/PENABLE stable for 4 ACCESS cycles, rsp_err=1, exactly one rsp_valid[0] pulse.
- Round-robin, NUM_REQ=3, all req_valid held high for 6 transfers
  -> grant order 0,1,2,0,1,2, every completion followed directly by SETUP, PSEL never drops.
- Back-to-back fairness: requester 1 re-requests immediately after each response while requester 0 is also pending
  -> grants alternate 0,1,0,1, and no requester is granted twice while another is pending.
- Reset mid-transfer: assert PRESETn=0 during ACCESS with PREADY=0
  -> next edge gives PSEL=PENABLE=0 and all req_ready=0. No rsp_valid is issued. After release, the first grant goes to requester 0.
- Protocol compliance: random valid/PREADY/PSLVERR traffic, 10k cycles, with the team APB checker bound on the bus
  -> zero checker failures, and response count equals accept count per requester.
